// File: rtl/vedic_mult_64_pipe.sv
// vedic_mult_64_pipe: pipelined 64x64 unsigned multiplier from four 32x32 Urdhva-Tiryagbhyam partial products
// Ports: clk (rising edge), rst_n (async active-low), a/b 64-bit unsigned operands, result 128-bit registered product.
// Latency 3 cycles, 4 with EXTRA_OUT_REG=1; one new operand pair accepted every cycle.
// Optional macro VEDIC_MULT_VALID_EN adds in_valid/out_valid tracking the datapath latency.
module vedic_mult_64_pipe #(
  parameter int unsigned EXTRA_OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef VEDIC_MULT_VALID_EN
  input  logic         in_valid,
  output logic         out_valid,
`endif
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] result
);
  logic [63:0]  a_q, a_d, b_q, b_d;
  logic [63:0]  p_ll_q, p_ll_d, p_lh_q, p_lh_d, p_hl_q, p_hl_d, p_hh_q, p_hh_d;
  logic [64:0]  mid;
  logic [127:0] sum_q, sum_d, out_q, out_d;
  always_comb begin
    a_d    = a;
    b_d    = b;
    p_ll_d = 64'(a_q[31:0])  * 64'(b_q[31:0]);
    p_lh_d = 64'(a_q[31:0])  * 64'(b_q[63:32]);
    p_hl_d = 64'(a_q[63:32]) * 64'(b_q[31:0]);
    p_hh_d = 64'(a_q[63:32]) * 64'(b_q[63:32]);
    // cross terms summed at 65 bits so their carry lands in bit 96
    mid    = {1'b0, p_lh_q} + {1'b0, p_hl_q};
    sum_d  = {64'd0, p_ll_q} + {31'd0, mid, 32'd0} + {p_hh_q, 64'd0};
    out_d  = sum_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_ll_q <= '0;
      p_lh_q <= '0;
      p_hl_q <= '0;
      p_hh_q <= '0;
      sum_q  <= '0;
      out_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_ll_q <= p_ll_d;
      p_lh_q <= p_lh_d;
      p_hl_q <= p_hl_d;
      p_hh_q <= p_hh_d;
      sum_q  <= sum_d;
      out_q  <= out_d;
    end
  end
  assign result = (EXTRA_OUT_REG != 0) ? out_q : sum_q;
`ifdef VEDIC_MULT_VALID_EN
  logic [3:0] v_q, v_d;
  always_comb v_d = {v_q[2:0], in_valid};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end
  assign out_valid = (EXTRA_OUT_REG != 0) ? v_q[3] : v_q[2];
`endif
endmodule

// File: tb/tb_vedic_mult_64_pipe.sv
// tb_vedic_mult_64_pipe: directed table-driven check of vedic_mult_64_pipe (default EXTRA_OUT_REG=0)
module tb_vedic_mult_64_pipe;
  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;
  } vec_t;
  localparam int NV = 12;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  a = '0;
  logic [63:0]  b = '0;
  logic [127:0] result;
`ifdef VEDIC_MULT_VALID_EN
  logic         in_valid = 1'b0;
  logic         out_valid;
`endif
  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [NV];
  vedic_mult_64_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VEDIC_MULT_VALID_EN
    .in_valid(in_valid),
    .out_valid(out_valid),
`endif
    .a(a),
    .b(b),
    .result(result)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0]  = '{64'd2, 64'd3, 128'd6};
    vecs[1]  = '{64'd5, 64'd7, 128'd35};
    vecs[2]  = '{64'd11, 64'd13, 128'd143};
    vecs[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFE0000000000000001};
    vecs[4]  = '{64'hFFFFFFFF00000001, 64'h00000001FFFFFFFF, 128'h00000001FFFFFFFD00000002FFFFFFFF};
    vecs[5]  = '{64'd0, 64'hDEADBEEFCAFEF00D, 128'd0};
    vecs[6]  = '{64'd1, 64'h0123456789ABCDEF, 128'h0123456789ABCDEF};
    vecs[7]  = '{64'hFEDCBA9876543210, 64'd1, 128'hFEDCBA9876543210};
    vecs[8]  = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000100000000, 128'h00000000FFFFFFFFFFFFFFFF00000000};
    vecs[9]  = '{64'h8000000000000000, 64'd2, 128'h00000000000000010000000000000000};
    vecs[10] = '{64'h8000000000000000, 64'h8000000000000000, 128'h40000000000000000000000000000000};
    vecs[11] = '{64'd123456789, 64'd125, 128'h397D32341};
    #5;
    chk("reset_result", result, 128'd0);
`ifdef VEDIC_MULT_VALID_EN
    chk("reset_valid", {127'd0, out_valid}, 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NV + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        chk($sformatf("stream%0d", k - 3), result, vecs[k - 3].p);
`ifdef VEDIC_MULT_VALID_EN
        chk($sformatf("stream_valid%0d", k - 3), {127'd0, out_valid}, {127'd0, k < NV + 3});
`endif
      end
      if (k < NV) begin
        a = vecs[k].a;
        b = vecs[k].b;
`ifdef VEDIC_MULT_VALID_EN
        in_valid = 1'b1;
`endif
      end
    end
    a = 64'd7;
    b = 64'd6;
    @(negedge clk);
    @(negedge clk);
    chk("latency_edge2", result, vecs[NV - 1].p);
    @(negedge clk);
    chk("latency_edge3", result, 128'd42);
    @(negedge clk);
    chk("hold", result, 128'd42);
    a = 64'd7;
    b = 64'd9;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_reset", result, 128'd0);
`ifdef VEDIC_MULT_VALID_EN
    chk("async_reset_valid", {127'd0, out_valid}, 128'd0);
`endif
    a = 64'd4;
    b = 64'd4;
    @(negedge clk);
    chk("reset_held", result, 128'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk($sformatf("post_reset_edge%0d", e), result, (e == 3) ? 128'd16 : 128'd0);
`ifdef VEDIC_MULT_VALID_EN
      chk($sformatf("post_reset_valid%0d", e), {127'd0, out_valid}, {127'd0, e == 3});
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
